// File: rtl/mv_top_ctrl.sv
// -----------------------------------------------------------------------------
// mv_top_ctrl
//
// Controller and client for the single-port top-MV line RAM. The RAM holds one
// macroblock row of 16-bit packed motion vectors, four entries per macroblock.
// For each macroblock this block reads the four MVs stored above the current
// MB (its top neighbours). It then overwrites the same four entries with the
// current MB's bottom-row MVs, so the next MB row finds them there. Because the
// RAM has a single port, the read and the write are done one after the other.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   start_i       one-cycle request pulse, only looked at while idle
//   mb_x_i        MB column, sampled with start_i
//   mb_y_i        MB row, sampled with start_i
//   bot_mv_i      bottom-row MVs of the current MB, block 0 in the low bits
//   busy_o        high from the cycle after acceptance through the done cycle
//   done_o        one-cycle completion pulse
//   top_avail_o   top_mv_o holds real neighbour MVs (not top row / invalid)
//   top_mv_o      top neighbour MVs, same packing as bot_mv_i
//   ram_ce_o      RAM chip enable
//   ram_we_o      RAM write enable
//   ram_addr_o    RAM address (4*mb_x + block)
//   ram_data_o    RAM write data
//   ram_data_i    RAM read data, valid one cycle after a read access
// -----------------------------------------------------------------------------
module mv_top_ctrl #(
   parameter int MV_W       = 16,
   parameter int ADDR_W     = 9,
   parameter int MB_XW      = 7,
   parameter int MB_YW      = 7,
   parameter int MB_X_TOTAL = 120
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [MB_XW-1:0]  mb_x_i,
   input  logic [MB_YW-1:0]  mb_y_i,
   input  logic [4*MV_W-1:0] bot_mv_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              top_avail_o,
   output logic [4*MV_W-1:0] top_mv_o,
   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [MV_W-1:0]   ram_data_o,
   input  logic [MV_W-1:0]   ram_data_i
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RWAIT,
      WR,
      DONE
   } state_t;

   state_t              state;
   state_t              state_n;
   logic [1:0]          beat;
   logic [1:0]          beat_n;
   logic [1:0]          beat_inc;

   logic [ADDR_W-1:0]   base;
   logic [4*MV_W-1:0]   bot;
   logic                with_top;
   logic                rd_pend;
   logic [1:0]          rd_idx;

   logic                accept;
   logic                out_of_range;
   logic [ADDR_W-1:0]   start_base;

   logic                busy_n;
   logic                done_n;
   logic                avail_n;
   logic                ce_n;
   logic                we_n;
   logic [ADDR_W-1:0]   addr_n;
   logic [MV_W-1:0]     wdata_n;

   assign accept       = (state == IDLE) && start_i;
   assign out_of_range = (mb_x_i >= MB_XW'(MB_X_TOTAL));
   assign start_base   = ADDR_W'({mb_x_i, 2'b00});
   assign beat_inc     = beat + 2'd1;

   // Next-state and next-output logic. Every output is registered, so this
   // block works out what each output should show during the following cycle.
   // The first RAM access is issued straight from the request inputs, which
   // puts the first beat on the port in the cycle right after acceptance.
   // Top-row MBs skip the read phase. Out-of-range columns go straight to DONE
   // without touching the RAM.
   always_comb begin
      state_n = state;
      beat_n  = beat;
      busy_n  = busy_o;
      done_n  = 1'b0;
      avail_n = top_avail_o;
      ce_n    = 1'b0;
      we_n    = 1'b0;
      addr_n  = ram_addr_o;
      wdata_n = ram_data_o;

      case (state)
         IDLE: begin
            if (start_i) begin
               busy_n  = 1'b1;
               avail_n = 1'b0;
               beat_n  = 2'd0;
               if (out_of_range) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else if (mb_y_i == '0) begin
                  state_n = WR;
                  ce_n    = 1'b1;
                  we_n    = 1'b1;
                  addr_n  = start_base;
                  wdata_n = bot_mv_i[MV_W-1:0];
               end else begin
                  state_n = RD;
                  ce_n    = 1'b1;
                  addr_n  = start_base;
               end
            end
         end

         RD: begin
            if (beat == 2'd3) begin
               state_n = RWAIT;
            end else begin
               beat_n = beat_inc;
               ce_n   = 1'b1;
               addr_n = base + ADDR_W'(beat_inc);
            end
         end

         RWAIT: begin
            state_n = WR;
            beat_n  = 2'd0;
            ce_n    = 1'b1;
            we_n    = 1'b1;
            addr_n  = base;
            wdata_n = bot[MV_W-1:0];
         end

         WR: begin
            if (beat == 2'd3) begin
               state_n = DONE;
               done_n  = 1'b1;
               avail_n = with_top;
            end else begin
               beat_n  = beat_inc;
               ce_n    = 1'b1;
               we_n    = 1'b1;
               addr_n  = base + ADDR_W'(beat_inc);
               wdata_n = bot[beat_inc*MV_W +: MV_W];
            end
         end

         DONE: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State register and registered outputs. Reset drops everything to zero
   // at once, which also abandons any RAM access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         beat        <= 2'd0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         top_avail_o <= 1'b0;
         ram_ce_o    <= 1'b0;
         ram_we_o    <= 1'b0;
         ram_addr_o  <= '0;
         ram_data_o  <= '0;
      end else begin
         state       <= state_n;
         beat        <= beat_n;
         busy_o      <= busy_n;
         done_o      <= done_n;
         top_avail_o <= avail_n;
         ram_ce_o    <= ce_n;
         ram_we_o    <= we_n;
         ram_addr_o  <= addr_n;
         ram_data_o  <= wdata_n;
      end
   end

   // Request latching and read-data capture. A read on the port this cycle
   // returns its data next cycle, so the read flag and the block index are
   // delayed by one cycle. That delayed copy steers the returning word into
   // its slot of top_mv_o. The block index equals the low address bits
   // because each MB's entries start on a multiple of four. Acceptance clears
   // top_mv_o, so top-row and out-of-range requests report zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base     <= '0;
         bot      <= '0;
         with_top <= 1'b0;
         rd_pend  <= 1'b0;
         rd_idx   <= 2'd0;
         top_mv_o <= '0;
      end else begin
         rd_pend <= ram_ce_o & ~ram_we_o;
         rd_idx  <= ram_addr_o[1:0];
         if (accept) begin
            base     <= start_base;
            bot      <= bot_mv_i;
            with_top <= !out_of_range && (mb_y_i != '0);
            top_mv_o <= '0;
         end else if (rd_pend) begin
            top_mv_o[rd_idx*MV_W +: MV_W] <= ram_data_i;
         end
      end
   end

endmodule

// File: doc/mv_top_ctrl.md
Name: mv_top_ctrl

Overview:
Controller and client that drives the 16-bit x 480-entry single-port top-MV line RAM for one macroblock row.
- Per macroblock (MB) it reads the four 4x4-block MVs stored above the current MB (top neighbours).
- It then overwrites the same four entries with the current MB's bottom-row MVs, for use by the next MB row.
- It sits between the MV prediction / ME pipeline and the line-RAM wrapper, and serialises read-then-write on the single port.

Parameters:
MV_W, 16, width of one packed MV entry (RAM word width)
ADDR_W, 9, RAM address width
MB_XW, 7, width of MB column index
MB_YW, 7, width of MB row index
MB_X_TOTAL, 120, MBs per row; valid mb_x is 0..MB_X_TOTAL-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  one-cycle request pulse; sampled only in IDLE
mb_x_i  in  MB_XW  MB column, sampled with start_i
mb_y_i  in  MB_YW  MB row, sampled with start_i
bot_mv_i  in  4*MV_W  current MB bottom-row MVs; [MV_W-1:0] is block 0 (leftmost); sampled with start_i
busy_o  out  1  high from the cycle after an accepted start through the done cycle
done_o  out  1  one-cycle completion pulse
top_avail_o  out  1  top MVs valid; held from done until next accepted start
top_mv_o  out  4*MV_W  top neighbour MVs, same packing as bot_mv_i; held until next accepted start
ram_ce_o  out  1  RAM chip enable, active high
ram_we_o  out  1  RAM write enable, active high
ram_addr_o  out  ADDR_W  RAM address, equal to 4*mb_x+i
ram_data_o  out  MV_W  RAM write data
ram_data_i  in  MV_W  RAM read data; valid one cycle after a read access

Behaviour:
- Reset (async, rst_n=0) sets: state IDLE; busy_o, done_o, top_avail_o, ram_ce_o, ram_we_o = 0; ram_addr_o, ram_data_o, top_mv_o = 0. RAM contents are not cleared.
- All outputs are registered.
- States: IDLE, RD (4 beats), RWAIT, WR (4 beats), DONE.
- Request acceptance: start_i=1 in IDLE at edge 0 latches mb_x, mb_y and bot_mv. start_i outside IDLE is ignored, with no queuing.
- mb_y!=0, cycle by cycle:
  - Cycles 1-4 (RD, i=0..3): ce=1, we=0, addr=4*mb_x+i.
  - ram_data_i of read i is captured into top_mv_o[i] at the end of cycle i+2.
  - Cycle 5 (RWAIT): ce=0; captures beat 3.
  - Cycles 6-9 (WR, i=0..3): ce=1, we=1, addr=4*mb_x+i, data=bot_mv[i].
  - Cycle 10 (DONE): done_o=1, top_avail_o=1, ce=0. IDLE at cycle 11. Total latency 10 cycles, start to done.
- mb_y==0 (top picture row):
  - No reads; top_mv_o is cleared to 0 at acceptance.
  - WR runs in cycles 1-4; done_o at cycle 5 with top_avail_o=0.
- mb_x_i >= MB_X_TOTAL: no RAM access. done_o pulses at cycle 1 with top_avail_o=0 and top_mv_o=0.
- A new start is accepted in the cycle done_o is deasserted (IDLE). Back-to-back requests therefore run at an 11-cycle period (6-cycle period for row 0).
- ce=0 in every cycle outside RD/WR. we=1 only in WR.
- Address arithmetic: addr = {mb_x,2'b00}+i, computed in ADDR_W bits with no wrap for valid mb_x (max 479).
- Reset asserted mid-operation aborts immediately. A partially written MB leaves those RAM entries undefined. The next accepted start behaves normally.

Test Plan:
- Reset then idle: ce=we=busy=done=0, top_mv_o=0.
- Row 0, mb_x=5, bot_mv={16'h0004,16'h0003,16'h0002,16'h0001} -> writes addr 20..23 with 1,2,3,4 in cycles 1-4. done at cycle 5, top_avail_o=0, top_mv_o=0.
- Row 1, mb_x=5, bot_mv={16'hD,16'hC,16'hB,16'hA} -> reads 20..23 in cycles 1-4; top_mv_o={4,3,2,1} at done (cycle 10), top_avail_o=1. RAM 20..23 then holds A..D.
- Boundaries: mb_x=119 -> addresses 476..479. mb_x=120 -> no ce, done at cycle 1, top_avail_o=0.
- start_i held high for 12 cycles -> exactly one op before done, next accepted at cycle 11. start_i pulsed during busy -> ignored.
- rst_n low at cycle 7 of a row-1 op -> all outputs 0 immediately. A fresh request afterwards completes in 10 cycles with the correct addresses.
